// File: rtl/shreg_pkg.sv
// Shared types for the parametrised shift register: command opcodes and control FSM states.
package shreg_pkg;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_SHL  = 2'b01,
    OP_SHR  = 2'b10,
    OP_ROTL = 2'b11
  } op_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/shreg_ctrl.sv
// Command controller: accepts start, saturates the shift count, runs one step per clock and
// generates busy/done. Drives load/shift enables and the latched op to the datapath.
module shreg_ctrl
  import shreg_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned AMT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [AMT_W-1:0] amt,
  output logic             load_en,
  output logic             shift_en,
  output logic [1:0]       shift_op,
  output logic             busy,
  output logic             done
);

  localparam logic [AMT_W-1:0] WidthAmt = AMT_W'(WIDTH);

  state_t           state_q;
  op_t              op_q;
  logic [AMT_W-1:0] cnt_q;
  logic [AMT_W-1:0] amt_sat;
  op_t              op_in;

  assign op_in    = op_t'(op);
  assign amt_sat  = (amt > WidthAmt) ? WidthAmt : amt;
  assign load_en  = (state_q == IDLE) && start && (op_in == OP_LOAD);
  assign shift_en = (state_q == SHIFT);
  assign shift_op = op_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= OP_LOAD;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (op_in == OP_LOAD || amt == '0) begin
              done <= 1'b1;
            end else begin
              op_q    <= op_in;
              cnt_q   <= amt_sat;
              busy    <= 1'b1;
              state_q <= SHIFT;
            end
          end
        end
        SHIFT: begin
          cnt_q <= cnt_q - AMT_W'(1);
          // Final step: hand back to IDLE so a new start is accepted on the done edge.
          if (cnt_q == AMT_W'(1)) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/param_shift_reg.sv
// Loadable shift/rotate register with true/complement outputs and a start/busy/done handshake.
// Define PARAM_SHIFT_REG_PARITY_EN to add a registered parity output equal to ^q.
module param_shift_reg
  import shreg_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned AMT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [AMT_W-1:0] amt,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qd,
`ifdef PARAM_SHIFT_REG_PARITY_EN
  output logic             parity,
`endif
  output logic             busy,
  output logic             done
);

  logic             load_en;
  logic             shift_en;
  logic [1:0]       shift_op;
  logic [WIDTH-1:0] q_d;

  shreg_ctrl #(
    .WIDTH(WIDTH)
  ) u_ctrl (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .amt     (amt),
    .load_en (load_en),
    .shift_en(shift_en),
    .shift_op(shift_op),
    .busy    (busy),
    .done    (done)
  );

  always_comb begin
    q_d = q;
    if (load_en) begin
      q_d = d;
    end else if (shift_en) begin
      case (op_t'(shift_op))
        OP_SHL:  q_d = {q[WIDTH-2:0], sin};
        OP_SHR:  q_d = {sin, q[WIDTH-1:1]};
        OP_ROTL: q_d = {q[WIDTH-2:0], q[WIDTH-1]};
        default: q_d = q;
      endcase
    end
  end

  // qd (and parity) derive from q_d so they always move on the same edge as q.
  always_ff @(posedge clk) begin
    if (rst) begin
      q  <= '0;
      qd <= '1;
    end else begin
      q  <= q_d;
      qd <= ~q_d;
    end
  end

`ifdef PARAM_SHIFT_REG_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      parity <= 1'b0;
    end else begin
      parity <= ^q_d;
    end
  end
`endif

endmodule

// File: tb/tb_param_shift_reg.sv
// Testbench for param_shift_reg (WIDTH=8): directed vector table, hand-written reset-abort
// sequence and randomized commands checked against an arithmetic reference model.
module tb_param_shift_reg;

  logic       clk;
  logic       rst;
  logic       start;
  logic [1:0] op;
  logic [3:0] amt;
  logic [7:0] d;
  logic       sin;
  logic [7:0] q;
  logic [7:0] qd;
  logic       busy;
  logic       done;
`ifdef PARAM_SHIFT_REG_PARITY_EN
  logic       parity;
`endif

  param_shift_reg #(
    .WIDTH(8)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .amt   (amt),
    .d     (d),
    .sin   (sin),
    .q     (q),
    .qd    (qd),
`ifdef PARAM_SHIFT_REG_PARITY_EN
    .parity(parity),
`endif
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int mq      = 0;  // model register value, 0..255

  typedef struct {
    logic [1:0] op;
    logic [3:0] amt;
    logic [7:0] d;
    logic [7:0] sin_pat;
    logic       poke;
    logic [7:0] exp_q;
    string      name;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_step(input logic [1:0] o, input int v, input int s);
    case (o)
      2'b01:   return (v * 2 + s) % 256;
      2'b10:   return v / 2 + s * 128;
      2'b11:   return (v * 2 + v / 128) % 256;
      default: return v;
    endcase
  endfunction

  task automatic chk_q(input string nm);
    chk({nm, ".q"}, 32'(q), 32'(mq));
    chk({nm, ".qd"}, 32'(qd), 32'(~mq & 255));
`ifdef PARAM_SHIFT_REG_PARITY_EN
    chk({nm, ".parity"}, 32'(parity), 32'(^(8'(mq))));
`endif
  endtask

  // Issues one command and checks every cycle until one cycle past its done pulse.
  task automatic do_cmd(input logic [1:0] o, input logic [3:0] a, input logic [7:0] dv,
                        input logic [7:0] sp, input logic poke, input string nm);
    int n;
    n = (a > 8) ? 8 : int'(a);
    start = 1'b1; op = o; amt = a; d = dv;
    tick();
    start = 1'b0; op = 2'($urandom); amt = 4'($urandom); d = 8'($urandom);
    if (o == 2'b00) mq = int'(dv);
    if (o == 2'b00 || n == 0) begin
      chk({nm, ".done"}, 32'(done), 1);
      chk({nm, ".busy"}, 32'(busy), 0);
      chk_q(nm);
    end else begin
      chk({nm, ".accept_busy"}, 32'(busy), 1);
      chk({nm, ".accept_done"}, 32'(done), 0);
      chk_q({nm, ".accept"});
      for (int i = 0; i < n; i++) begin
        sin = sp[i];
        if (poke) begin
          start = 1'b1; op = 2'b00; d = 8'($urandom);
        end
        tick();
        mq = model_step(o, mq, int'(sp[i]));
        chk_q($sformatf("%s.step%0d", nm, i));
        chk($sformatf("%s.busy%0d", nm, i), 32'(busy), (i < n - 1) ? 1 : 0);
        chk($sformatf("%s.done%0d", nm, i), 32'(done), (i < n - 1) ? 0 : 1);
      end
      start = 1'b0;
    end
    tick();
    chk({nm, ".done_clear"}, 32'(done), 0);
    chk({nm, ".idle_busy"}, 32'(busy), 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'b00; amt = 4'd0; d = 8'h00; sin = 1'b0;
    tick();
    tick();
    chk("reset.q", 32'(q), 32'h00);
    chk("reset.qd", 32'(qd), 32'hFF);
    chk("reset.busy", 32'(busy), 0);
    chk("reset.done", 32'(done), 0);
`ifdef PARAM_SHIFT_REG_PARITY_EN
    chk("reset.parity", 32'(parity), 0);
`endif
    rst = 1'b0;
    mq  = 0;

    // op, amt, d, sin pattern (bit i used on shift i), poke-while-busy, expected q, name
    vecs.push_back('{2'b00, 4'd0,  8'h3C, 8'h00, 1'b0, 8'h3C, "load3c"});
    vecs.push_back('{2'b00, 4'd0,  8'h81, 8'h00, 1'b0, 8'h81, "load81"});
    vecs.push_back('{2'b11, 4'd3,  8'h00, 8'hFF, 1'b0, 8'h0C, "rotl3"});
    vecs.push_back('{2'b00, 4'd0,  8'hF0, 8'h00, 1'b0, 8'hF0, "loadf0"});
    vecs.push_back('{2'b10, 4'd2,  8'h00, 8'h01, 1'b1, 8'h7C, "shr2"});
    vecs.push_back('{2'b01, 4'd0,  8'h55, 8'hFF, 1'b0, 8'h7C, "shl0"});
    vecs.push_back('{2'b01, 4'd15, 8'h00, 8'h00, 1'b0, 8'h00, "shl15"});
    vecs.push_back('{2'b00, 4'd0,  8'h07, 8'h00, 1'b0, 8'h07, "load07"});
    vecs.push_back('{2'b01, 4'd1,  8'h00, 8'h01, 1'b0, 8'h0F, "shl1"});
    vecs.push_back('{2'b10, 4'd8,  8'h00, 8'hA5, 1'b0, 8'hA5, "shr8"});

    foreach (vecs[i]) begin
      do_cmd(vecs[i].op, vecs[i].amt, vecs[i].d, vecs[i].sin_pat, vecs[i].poke, vecs[i].name);
      chk({vecs[i].name, ".table_q"}, 32'(q), 32'(vecs[i].exp_q));
    end

    // Reset two shifts into SHL by 5: everything clears and no done pulse follows.
    do_cmd(2'b00, 4'd0, 8'hA5, 8'h00, 1'b0, "abort_load");
    start = 1'b1; op = 2'b01; amt = 4'd5;
    tick();
    start = 1'b0;
    sin = 1'b1;
    tick();
    tick();
    chk("abort.mid_busy", 32'(busy), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mq = 0;
    chk_q("abort");
    chk("abort.busy", 32'(busy), 0);
    chk("abort.done", 32'(done), 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("abort.no_done%0d", i), 32'(done), 0);
      chk($sformatf("abort.q%0d", i), 32'(q), 0);
    end

    for (int r = 0; r < 40; r++) begin
      do_cmd(2'($urandom), 4'($urandom), 8'($urandom), 8'($urandom),
             1'($urandom_range(0, 1)), $sformatf("rand%0d", r));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/param_shift_reg.md
# param_shift_reg

Parametrised multi-bit register with parallel load and multi-cycle shift/rotate, the next generation of the team's single-bit D flip-flop. It keeps the true/complement output pair (q/qd) and adds width, serial input, and a start/busy/done command handshake. A shift-by-N command executes one bit per clock. It sits in the datapath wherever a loadable, shiftable register with a completion flag is needed.

## Interface
- WIDTH, 8, register width in bits (≥2)
- AMT_W, derived localparam = $clog2(WIDTH+1), width of shift amount
- clk  input  1  rising-edge clock; all state changes on posedge clk
- rst  input  1  synchronous, active-high reset
- start  input  1  command strobe, accepted only when busy=0
- op  input  2  command: 00 LOAD, 01 SHL, 10 SHR, 11 ROTL
- amt  input  AMT_W  shift/rotate count for SHL/SHR/ROTL; ignored for LOAD
- d  input  WIDTH  parallel load data
- sin  input  1  serial input bit, sampled live on every shift edge
- q  output  WIDTH  register contents
- qd  output  WIDTH  registered complement, always ~q
- busy  output  1  shift operation in progress
- done  output  1  one-cycle completion pulse

## Operation
- Reset (rst=1 at an edge): q=0, qd={WIDTH{1}}, busy=0, done=0, FSM=IDLE, counter=0. Reset takes priority over everything, including mid-shift; an aborted operation produces no done pulse.
- FSM states: IDLE, SHIFT.
- IDLE, start=1, op=LOAD: q<=d, qd<=~d, done<=1; stays IDLE.
- IDLE, start=1, shift op, amt=0: q unchanged, done<=1; stays IDLE.
- IDLE, start=1, shift op, amt≥1: latch op, counter<=min(amt,WIDTH) (amt>WIDTH saturates to WIDTH), busy<=1 → SHIFT; q unchanged on this edge.
- SHIFT, each edge: apply one step, counter decrements. On the edge where counter goes 1→0: busy<=0, done<=1 → IDLE.
  - SHL: q<={q[WIDTH-2:0], sin}
  - SHR: q<={sin, q[WIDTH-1:1]}
  - ROTL: q<={q[WIDTH-2:0], q[WIDTH-1]}; sin ignored
- start while busy=1 is ignored and is not queued. op/amt/d changes during SHIFT have no effect.
- done is 0 on every edge except the completion edges listed above.

## Timing
- LOAD: start at edge k → q=d and done=1 after edge k. Latency 1.
- Shift amt=N (1..WIDTH): accept at edge k → busy=1 after k. Shifts occur at edges k+1..k+N. After edge k+N: busy=0, done=1. Total latency N+1 edges.
- Back-to-back: a new start is accepted on the same edge on which done is 1, since busy is already 0.
- qd changes on the same edge as q; there is no combinational path from inputs to outputs.

## Configuration
- PARAM_SHIFT_REG_PARITY_EN defined: adds output port parity (1 bit), registered, equal to ^q. It updates on the same edge as q and resets to 0.
- Not defined: the parity port and its logic are absent; all other behaviour is identical.

## Structure
- Package shreg_pkg:
  - op_t enum (OP_LOAD=2'b00, OP_SHL=2'b01, OP_SHR=2'b10, OP_ROTL=2'b11)
  - state_t enum (IDLE, SHIFT)
- Sub-module shreg_ctrl: FSM, counter, amount saturation, busy/done generation. It emits a one-bit shift-enable and the latched op.
- Top level holds the q/qd datapath (and parity when enabled).

## Test plan
- Reset mid-SHIFT (WIDTH=8, load 8'hA5, SHL amt=5, assert rst after 2 shifts) → q=8'h00, qd=8'hFF, busy=0, and no done pulse follows.
- LOAD d=8'h3C → after 1 edge q=8'h3C, qd=8'hC3, done=1 for exactly one cycle, busy never 1.
- q=8'h81, ROTL amt=3 → busy for 3 cycles, then q=8'h0C, done=1.
- q=8'hF0, SHR amt=2 with sin=1 then 0 → q=8'h7C after 2 shifts, done pulse; start issued during busy is ignored.
- SHL amt=0 → q unchanged, done=1 next cycle. SHL amt=15 on WIDTH=8 (AMT_W=4), sin=0 → saturates to 8 shifts, q=8'h00, busy for exactly 8 cycles.
- PARAM_SHIFT_REG_PARITY_EN defined: load 8'h07 → parity=1; SHL amt=1 with sin=1 → q=8'h0F, parity=0.
